counter_share_ctrl: RTL and testbench

- Controller and arbiter for a shared 4-bit up-counter used as a cycle-delay timer by several requesters.
- Each requester asks for a delay of LEN cycles. A round-robin arbiter grants the counter to one requester at a time. The FSM clears the counter, lets it count up to LEN, then returns a one-cycle done pulse.
- Sits between control logic that needs timed waits and the counter datapath, which is internal to this block.

---
 rtl/counter_share_ctrl_pkg.sv | 13 +
 rtl/counter_share_ctrl_rr_arbiter.sv | 32 +++
 rtl/counter_share_ctrl.sv | 120 ++++++++++++
 tb/tb_counter_share_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_share_ctrl_pkg.sv
// Shared types and defaults for the shared delay-counter controller.
package counter_share_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/counter_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module counter_share_ctrl_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PW-1:0]    win,
    output logic             found
);

    logic [PW-1:0] k;

    always_comb begin
        pick  = '0;
        win   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        if (found) begin
            pick[win] = 1'b1;
        end
    end

endmodule

// File: rtl/counter_share_ctrl.sv
// Arbitrates a shared up-counter among requesters and runs one timed wait per grant.
//   state    | meaning
//   ST_IDLE  | no grant; arbitrate pending requests
//   ST_COUNT | counter running from 0 up to latched length
//   ST_DONE  | one-cycle done pulse, grant still held
module counter_share_ctrl
    import counter_share_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [WIDTH-1:0]       cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d, len_sel;
    logic [N_REQ-1:0] gnt_q, gnt_d, pick;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    win;
    logic             found;

    counter_share_ctrl_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .win   (win),
        .found (found)
    );

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                len_sel = len[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    state_d = ST_COUNT;
                    gnt_d   = pick;
                    gidx_d  = win;
                    len_d   = len_sel;
                    ptr_d   = (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            ST_COUNT: begin
                // Abort takes priority over reaching the terminal count.
                if (!req[gidx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    // Outputs decode straight from registers so an async reset clears them at once.
    assign gnt  = gnt_q;
    assign done = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy = (state_q != ST_IDLE);
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Scenario bench for counter_share_ctrl: expected transactions queued at stimulus, compared on completion.
module tb_counter_share_ctrl;

    localparam int N = 2;
    localparam int W = 4;

    typedef struct {
        int id;
        int len;
        int abort_at;
    } exp_t;

    logic           clock = 1'b0;
    logic           clear;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   trace[$];

    logic [N-1:0] o_gnt;
    int           o_wait, o_ncyc, o_ndone;
    bit           o_bad, o_to, o_busy;

    counter_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
        .clock (clock),
        .clear (clear),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clock);
    endtask

    // Collects one transaction's observable behaviour; no judgement here.
    task automatic observe(input int abort_at, input bit drop);
        trace.delete();
        o_gnt = '0; o_wait = 0; o_ncyc = 0; o_ndone = 0;
        o_bad = 1'b0; o_to = 1'b0; o_busy = 1'b1;
        while (gnt == '0 && o_wait < 40) begin
            tick();
            o_wait++;
        end
        if (gnt == '0) begin
            o_to = 1'b1;
            return;
        end
        o_gnt = gnt;
        while (gnt != '0 && o_ncyc < 40) begin
            trace.push_back(int'(cnt));
            o_ncyc++;
            if (!$onehot(gnt) || gnt !== o_gnt || (done & ~gnt) != '0 || $countones(done) > 1)
                o_bad = 1'b1;
            if (done != '0) begin
                o_ndone++;
                if (drop) req = req & ~gnt;
            end
            if (abort_at >= 0 && int'(cnt) == abort_at) req = req & ~gnt;
            tick();
        end
        if (gnt != '0) o_to = 1'b1;
        o_busy = busy;
    endtask

    // Index of the first cnt sample that departs from the reference sequence, -1 if none.
    function automatic int first_bad(exp_t e);
        int n;
        int ex;
        n = (e.abort_at >= 0) ? e.abort_at + 1 : e.len + 2;
        if (trace.size() != n) return -2;
        for (int j = 0; j < n; j++) begin
            ex = (j <= e.len) ? j : e.len;
            if (trace[j] != ex) return j;
        end
        return -1;
    endfunction

    task automatic test_reset;
        exp_t e;
        logic [N-1:0] eg;
        int fb;
        clear = 1'b0; req = 2'b11; len = 8'h33;
        tick(); tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
        clear = 1'b1; req = 2'b01; len = 8'h03;
        sb.push_back('{0, 3, -1});
        observe(-1, 1'b1);
        e = sb.pop_front();
        eg = 2'(1 << e.id);
        fb = first_bad(e);
        checks++; if (o_to || o_wait != 1) begin errors++; $display("FAIL first_grant_latency: got %0d cycles (timeout=%0b) want 1", o_wait, o_to); end
        checks++; if (o_gnt !== eg) begin errors++; $display("FAIL first_gnt: got %b want %b", o_gnt, eg); end
        checks++; if (fb != -1) begin errors++; $display("FAIL first_cnt_seq: bad at index %0d want none", fb); end
        checks++; if (o_ndone != 1 || o_bad) begin errors++; $display("FAIL first_done: got %0d pulses (viol=%0b) want 1", o_ndone, o_bad); end
        checks++; if (o_ncyc != 5 || o_busy !== 1'b0) begin errors++; $display("FAIL first_busy_drop: got %0d cycles busy=%b want 5 busy=0", o_ncyc, o_busy); end
    endtask

    task automatic test_round_robin;
        exp_t e;
        logic [N-1:0] eg;
        int fb;
        clear = 1'b0; req = 2'b00;
        tick();
        clear = 1'b1; len = {4'd2, 4'd1}; req = 2'b11;
        sb.push_back('{0, 1, -1}); sb.push_back('{1, 2, -1});
        sb.push_back('{0, 1, -1}); sb.push_back('{1, 2, -1});
        for (int k = 0; k < 4; k++) begin
            observe(-1, 1'b0);
            e = sb.pop_front();
            eg = 2'(1 << e.id);
            fb = first_bad(e);
            checks++; if (o_to || o_wait != 1) begin errors++; $display("FAIL rr_latency[%0d]: got %0d cycles (timeout=%0b) want 1", k, o_wait, o_to); end
            checks++; if (o_gnt !== eg) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, o_gnt, eg); end
            checks++; if (fb != -1) begin errors++; $display("FAIL rr_cnt_seq[%0d]: bad at index %0d want none", k, fb); end
            checks++; if (o_ndone != 1 || o_bad) begin errors++; $display("FAIL rr_done[%0d]: got %0d pulses (viol=%0b) want 1", k, o_ndone, o_bad); end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_boundaries;
        exp_t e;
        logic [N-1:0] eg;
        int fb;
        len = {4'd15, 4'd0};
        req = 2'b01;
        sb.push_back('{0, 0, -1});
        observe(-1, 1'b1);
        e = sb.pop_front(); eg = 2'(1 << e.id); fb = first_bad(e);
        checks++; if (o_to || o_gnt !== eg) begin errors++; $display("FAIL len0_gnt: got %b (timeout=%0b) want %b", o_gnt, o_to, eg); end
        checks++; if (fb != -1 || o_ncyc != 2) begin errors++; $display("FAIL len0_timing: bad index %0d, %0d cycles, want none and 2", fb, o_ncyc); end
        checks++; if (o_ndone != 1 || o_bad) begin errors++; $display("FAIL len0_done: got %0d pulses (viol=%0b) want 1", o_ndone, o_bad); end
        req = 2'b10;
        sb.push_back('{1, 15, -1});
        observe(-1, 1'b1);
        e = sb.pop_front(); eg = 2'(1 << e.id); fb = first_bad(e);
        checks++; if (o_to || o_gnt !== eg) begin errors++; $display("FAIL len15_gnt: got %b (timeout=%0b) want %b", o_gnt, o_to, eg); end
        checks++; if (fb != -1) begin errors++; $display("FAIL len15_no_wrap: bad at index %0d want none", fb); end
        checks++; if (o_ndone != 1 || o_bad) begin errors++; $display("FAIL len15_done: got %0d pulses (viol=%0b) want 1", o_ndone, o_bad); end
    endtask

    task automatic test_abort;
        exp_t e;
        logic [N-1:0] eg;
        int fb;
        len = {4'd10, 4'd2};
        req = 2'b10;
        tick();
        req = 2'b11;
        sb.push_back('{1, 10, 4});
        observe(4, 1'b0);
        e = sb.pop_front(); eg = 2'(1 << e.id); fb = first_bad(e);
        checks++; if (o_to || o_gnt !== eg) begin errors++; $display("FAIL abort_gnt: got %b (timeout=%0b) want %b", o_gnt, o_to, eg); end
        checks++; if (fb != -1) begin errors++; $display("FAIL abort_cnt_seq: bad at index %0d want none", fb); end
        checks++; if (o_ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", o_ndone); end
        checks++; if (cnt !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got cnt=%0d busy=%b want 0 0", cnt, busy); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL abort_pending_gnt: got %b want 01", gnt); end
        sb.push_back('{0, 2, -1});
        observe(-1, 1'b1);
        e = sb.pop_front(); eg = 2'(1 << e.id); fb = first_bad(e);
        checks++; if (fb != -1 || o_ndone != 1) begin errors++; $display("FAIL pending_txn: bad index %0d, %0d pulses, want none and 1", fb, o_ndone); end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int w;
        int fb;
        len = {4'd12, 4'd0};
        req = 2'b10;
        w = 0;
        while (cnt != 4'd6 && w < 40) begin
            tick();
            w++;
        end
        checks++; if (cnt !== 4'd6) begin errors++; $display("FAIL midrst_reach6: got cnt=%0d want 6", cnt); end
        #2 clear = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00 || done !== 2'b00) begin errors++; $display("FAIL midrst_gnt_done: got %b %b want 00 00", gnt, done); end
        checks++; if (busy !== 1'b0 || cnt !== 4'd0) begin errors++; $display("FAIL midrst_busy_cnt: got busy=%b cnt=%0d want 0 0", busy, cnt); end
        tick();
        clear = 1'b1; req = 2'b11;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_ptr: got %b want 01", gnt); end
        req = 2'b01;
        sb.push_back('{0, 0, -1});
        observe(-1, 1'b1);
        e = sb.pop_front(); fb = first_bad(e);
        checks++; if (o_to || fb != -1 || o_ndone != 1) begin errors++; $display("FAIL midrst_txn: bad index %0d, %0d pulses, timeout=%0b", fb, o_ndone, o_to); end
    endtask

    task automatic test_len_stable;
        exp_t e;
        int fb;
        len = {4'd0, 4'd5};
        req = 2'b01;
        sb.push_back('{0, 5, -1});
        tick();
        len = {4'd0, 4'd2};
        observe(-1, 1'b1);
        e = sb.pop_front(); fb = first_bad(e);
        checks++; if (o_to || o_gnt !== 2'b01) begin errors++; $display("FAIL stable_gnt: got %b (timeout=%0b) want 01", o_gnt, o_to); end
        checks++; if (fb != -1) begin errors++; $display("FAIL stable_len_latched: bad at index %0d want none", fb); end
        checks++; if (o_ndone != 1 || o_bad) begin errors++; $display("FAIL stable_done: got %0d pulses (viol=%0b) want 1", o_ndone, o_bad); end
    endtask

    initial begin
        clear = 1'b0;
        req   = '0;
        len   = '0;
        tick();
        test_reset();
        test_round_robin();
        test_boundaries();
        test_abort();
        test_mid_reset();
        test_len_stable();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
